// File: rtl/mult_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: state encoding,
// default operand width and iteration-counter sizing.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter must hold WIDTH-1; never let it collapse to zero bits.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/shift_add_core.sv
// Iterative shift-add datapath: magnitude capture, one partial-product add per
// step, and the final sign fix-up of the 2*WIDTH product.
module shift_add_core
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_signed_i,
  input  logic [WIDTH-1:0]   srca_i,
  input  logic [WIDTH-1:0]   srcb_i,
  output logic [2*WIDTH-1:0] product_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mplier_q;
  logic               neg_q;
  logic [WIDTH:0]     sum;

  // The most-negative value negates to itself, which is its correct
  // unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // NOTE: every variable driven here gets a value on all paths, so no latch
  // is inferred.
  always_comb begin
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, mcand_q} & {(WIDTH+1){mplier_q[0]}});
    acc_d = {sum, acc_q[WIDTH-1:1]};
  end

  // Commit happens on the last step, so the product is taken from acc_d.
  assign product_o = neg_q ? -acc_d : acc_d;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else if (load_i) begin
      acc_q    <= '0;
      mcand_q  <= magnitude(srca_i, is_signed_i);
      mplier_q <= magnitude(srcb_i, is_signed_i);
      neg_q    <= is_signed_i & (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
    end else if (step_i) begin
      acc_q    <= acc_d;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// HI/LO multiply sequencer for the single-cycle MIPS core: FSM, iteration
// counter, HI/LO registers and the pipeline stall.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mf_req,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CntW = cnt_width(WIDTH);

  state_e             state_q;
  logic [CntW-1:0]    count_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;
  logic               accept;
  logic [2*WIDTH-1:0] product;

  assign accept = start & (state_q != S_RUN);

  shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .reset       (reset),
    .load_i      (accept),
    .step_i      (busy_q),
    .is_signed_i (is_signed),
    .srca_i      (srca),
    .srcb_i      (srcb),
    .product_o   (product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            count_q <= CntW'(WIDTH - 1);
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            if (mthi) hi_q <= srca;
            if (mtlo) lo_q <= srca;
          end
        end
        S_RUN: begin
          if (count_q == '0) begin
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            {hi_q, lo_q} <= product;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Any HI/LO access while running is held off; the core re-presents it.
  assign stall = busy_q & (start | mf_req | mthi | mtlo);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed corner cases plus random
// operands, compared against a plain-arithmetic product model.
module tb_mult_seq_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, is_signed, mf_req, mthi, mtlo;
  logic [W-1:0] srca, srcb;
  logic [W-1:0] hi, lo;
  logic         busy, done, stall;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] model_hilo;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .srca      (srca),
    .srcb      (srcb),
    .mf_req    (mf_req),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_prod(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (sgn) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Issues one multiply and follows it to commit. req_at >= 0 raises mf_req
  // (or mthi when req_mt) that many cycles after acceptance.
  task automatic run_mult(input string tag, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input int req_at, input bit req_mt,
                          input bit keep_done);
    logic [63:0] expv;
    int cnt;
    expv      = ref_prod(sgn, a, b);
    start     = 1'b1;
    is_signed = sgn;
    srca      = a;
    srcb      = b;
    #1;
    check({tag, ":accept_stall"}, stall, 0);
    tick();
    start     = 1'b0;
    srca      = $urandom;
    srcb      = $urandom;
    is_signed = 1'($urandom);
    cnt = 0;
    while (1'b1) begin
      tick();
      cnt++;
      if (done === 1'b1 || cnt >= 100) break;
      check({tag, ":busy_run"}, busy, 1);
      check({tag, ":hilo_hold"}, {hi, lo}, model_hilo);
      if (req_at >= 0 && cnt > req_at) check({tag, ":stall_run"}, stall, 1);
      if (cnt == req_at) begin
        if (req_mt) begin
          mthi = 1'b1;
          srca = 32'hDEAD_BEEF;
        end else begin
          mf_req = 1'b1;
        end
      end
    end
    check({tag, ":latency"}, 64'(cnt), 64'(W));
    check({tag, ":done"}, done, 1);
    check({tag, ":busy_done"}, busy, 0);
    check({tag, ":stall_done"}, stall, 0);
    check({tag, ":hi"}, hi, expv[63:32]);
    check({tag, ":lo"}, lo, expv[31:0]);
    model_hilo = expv;
    mf_req = 1'b0;
    mthi   = 1'b0;
    if (!keep_done) begin
      tick();
      check({tag, ":done_pulse"}, done, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 0; is_signed = 0; mf_req = 0; mthi = 0; mtlo = 0;
    srca = '0; srcb = '0;
    model_hilo = '0;
    #1;
    check("rst:hi", hi, 0);
    check("rst:lo", lo, 0);
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:stall", stall, 0);
    #11 reset = 1'b0;
    tick();

    // Moves to HI/LO while idle.
    mthi = 1'b1; srca = 32'h0000_1234;
    tick();
    mthi = 1'b0; mtlo = 1'b1; srca = 32'h0000_5678;
    tick();
    mtlo = 1'b0;
    check("mt:hi", hi, 32'h1234);
    check("mt:lo", lo, 32'h5678);
    mthi = 1'b1; mtlo = 1'b1; srca = 32'hCAFE_F00D;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_both:hilo", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);
    model_hilo = 64'hCAFE_F00D_CAFE_F00D;

    run_mult("multu_6x4", 1'b0, 32'd6, 32'd4, -1, 1'b0, 1'b0);
    check("multu_6x4:const", {hi, lo}, 64'h0000_0000_0000_0018);

    run_mult("mult_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 3, 1'b0, 1'b0);
    check("mult_m3x5:const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    run_mult("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 1'b0);
    check("multu_max:const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_mult("mult_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, -1, 1'b0, 1'b0);
    check("mult_minxmin:const", {hi, lo}, 64'h4000_0000_0000_0000);

    // Back-to-back: second start issued on the done cycle, mthi blocked mid-run.
    run_mult("mult_minx1", 1'b1, 32'h8000_0000, 32'd1, -1, 1'b0, 1'b1);
    check("mult_minx1:const", {hi, lo}, 64'hFFFF_FFFF_8000_0000);
    run_mult("b2b_mthi", 1'b1, 32'h0001_0003, 32'hFFF0_0007, 5, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i == 2) ra[31] = 1'b1;
      if (i == 3) rb[31] = 1'b1;
      run_mult($sformatf("rand%0d", i), 1'($urandom), ra, rb, -1, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-run abandons the multiply.
    start = 1'b1; is_signed = 1'b0; srca = 32'h1234_5678; srcb = 32'h9ABC_DEF0;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 reset = 1'b1;
    #1;
    check("midrst:hi", hi, 0);
    check("midrst:lo", lo, 0);
    check("midrst:busy", busy, 0);
    check("midrst:done", done, 0);
    check("midrst:stall", stall, 0);
    model_hilo = '0;
    @(negedge clk) reset = 1'b0;
    tick();
    run_mult("multu_7x7", 1'b0, 32'd7, 32'd7, -1, 1'b0, 1'b0);
    check("multu_7x7:lo", lo, 32'h31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
